// File: rtl/mem_stage_pkg.sv
// mem_stage shared definitions: load-op encoding and MEM state encoding.
// Optional bypass export is enabled by defining MS_FWD_EN.
package mem_stage_pkg;

  localparam int         LD_SIGN   = 2;
  localparam logic [1:0] LD_SIZE_B = 2'b00;
  localparam logic [1:0] LD_SIZE_H = 2'b01;
  localparam logic [1:0] LD_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } ms_state_e;

  function automatic logic [1:0] ld_size(input logic [2:0] op);
    return op[1:0];
  endfunction

endpackage

// File: rtl/mem_stage_load_extract.sv
// Load lane select and sign/zero extension; purely combinational.
module load_extract
  import mem_stage_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_op,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sign;
  logic [1:0]  size;

  always_comb begin
    sign   = ld_op[LD_SIGN];
    size   = ld_size(ld_op);
    b      = data[{addr, 3'b000} +: 8];
    h      = data[{addr[1], 4'b0000} +: 16];
    result = data;
    unique case (1'b1)
      size == LD_SIZE_B: result = {{24{sign & b[7]}}, b};
      size == LD_SIZE_H: result = {{16{sign & h[15]}}, h};
      size == LD_SIZE_W: result = data;
      default:           result = data;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM response, extends loads, feeds WB.
// Define MS_FWD_EN to drive the ms_fwd_* bypass bundle (else tied to 0).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [31:0] es_pc,
  input  logic [31:0] es_rf_wdata,
  input  logic [4:0]  es_rf_waddr,
  input  logic        es_rf_we,
  input  logic        es_mem_req,
  input  logic        es_is_load,
  input  logic [2:0]  es_ld_op,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [31:0] ms_rf_wdata,
  output logic [4:0]  ms_rf_waddr,
  output logic        ms_rf_we,
  output logic        ms_fwd_we,
  output logic [4:0]  ms_fwd_waddr,
  output logic [31:0] ms_fwd_wdata,
  output logic        ms_fwd_ready
);

  ms_state_e   state;
  ms_state_e   nstate;
  logic        ms_valid;
  logic        ms_ready_go;
  logic        accept;
  logic        capture;
  logic [31:0] pc_q;
  logic [31:0] wdata_q;
  logic [4:0]  waddr_q;
  logic        we_q;
  logic        is_load_q;
  logic [2:0]  ld_op_q;
  logic [31:0] buf_q;
  logic [31:0] ld_src;
  logic [31:0] ld_val;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (ms_allowin) begin
      if (!es_to_ms_valid) nstate = IDLE;
      else if (es_mem_req) nstate = WAIT;
      else                 nstate = READY;
    end else if (state == WAIT && data_sram_data_ok) begin
      nstate = READY;
    end
  end

  always_comb begin
    ms_valid       = state != IDLE;
    ms_ready_go    = (state == READY) |
                     ((state == WAIT) & data_sram_data_ok);
    ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    ms_to_ws_valid = ms_valid & ms_ready_go;
    accept         = es_to_ms_valid & ms_allowin;
    capture        = (state == WAIT) & data_sram_data_ok &
                     ~ws_allowin;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q      <= PC_RESET;
      wdata_q   <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      ld_op_q   <= '0;
    end else if (accept) begin
      pc_q      <= es_pc;
      wdata_q   <= es_rf_wdata;
      waddr_q   <= es_rf_waddr;
      we_q      <= es_rf_we;
      is_load_q <= es_is_load;
      ld_op_q   <= es_ld_op;
    end
  end

  // Holds the response only while WB back-pressures the stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      buf_q <= '0;
    else if (capture) buf_q <= data_sram_rdata;
  end

  assign ld_src = (state == READY) ? buf_q : data_sram_rdata;

  load_extract u_load_extract (
    .data   (ld_src),
    .addr   (wdata_q[1:0]),
    .ld_op  (ld_op_q),
    .result (ld_val)
  );

  assign ms_pc       = pc_q;
  assign ms_rf_waddr = waddr_q;
  assign ms_rf_we    = ms_valid & we_q;
  assign ms_rf_wdata = is_load_q ? ld_val : wdata_q;

`ifdef MS_FWD_EN
  assign ms_fwd_we    = ms_valid & ms_rf_we;
  assign ms_fwd_waddr = ms_rf_waddr;
  assign ms_fwd_wdata = ms_rf_wdata;
  assign ms_fwd_ready = ms_ready_go;
`else
  assign ms_fwd_we    = 1'b0;
  assign ms_fwd_waddr = 5'd0;
  assign ms_fwd_wdata = 32'd0;
  assign ms_fwd_ready = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against a transaction model.
// Bypass expectations follow MS_FWD_EN.
module tb_mem_stage;

`ifdef MS_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [31:0] es_rf_wdata;
  logic [4:0]  es_rf_waddr;
  logic        es_rf_we;
  logic        es_mem_req;
  logic        es_is_load;
  logic [2:0]  es_ld_op;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_rf_wdata;
  logic [4:0]  ms_rf_waddr;
  logic        ms_rf_we;
  logic        ms_fwd_we;
  logic [4:0]  ms_fwd_waddr;
  logic [31:0] ms_fwd_wdata;
  logic        ms_fwd_ready;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_pc             (es_pc),
    .es_rf_wdata       (es_rf_wdata),
    .es_rf_waddr       (es_rf_waddr),
    .es_rf_we          (es_rf_we),
    .es_mem_req        (es_mem_req),
    .es_is_load        (es_is_load),
    .es_ld_op          (es_ld_op),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_rf_wdata       (ms_rf_wdata),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_rf_we          (ms_rf_we),
    .ms_fwd_we         (ms_fwd_we),
    .ms_fwd_waddr      (ms_fwd_waddr),
    .ms_fwd_wdata      (ms_fwd_wdata),
    .ms_fwd_ready      (ms_fwd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load result from byte offset, width and sign.
  function automatic logic [31:0] ref_load(input logic [31:0] d,
                                           input logic [1:0] a,
                                           input logic [2:0] op);
    longint unsigned v;
    int unsigned     bits;
    int unsigned     sh;
    int unsigned     off;
    off  = {30'd0, a};
    bits = (op[1:0] == 2'd0) ? 8 : (op[1:0] == 2'd1) ? 16 : 32;
    sh   = (bits == 8) ? off * 8 : (bits == 16) ? (off / 2) * 16 : 0;
    v    = ({32'd0, d} >> sh) & ((64'd1 << bits) - 64'd1);
    if (op[2] && bits < 32 && v >= (64'd1 << (bits - 1)))
      v = v + (64'd1 << 32) - (64'd1 << bits);
    return v[31:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_es(input logic [31:0] pc, input logic [31:0] wd,
                          input logic [4:0] wa, input logic we,
                          input logic mreq, input logic ld,
                          input logic [2:0] op);
    es_to_ms_valid = 1'b1;
    es_pc          = pc;
    es_rf_wdata    = wd;
    es_rf_waddr    = wa;
    es_rf_we       = we;
    es_mem_req     = mreq;
    es_is_load     = ld;
    es_ld_op       = op;
  endtask

  task automatic chk_wb(input string tag, input logic v,
                        input logic [31:0] pc, input logic [31:0] wd,
                        input logic [4:0] wa, input logic we);
    chk1({tag, ".valid"}, ms_to_ws_valid, v);
    chk32({tag, ".pc"}, ms_pc, pc);
    chk32({tag, ".wdata"}, ms_rf_wdata, wd);
    chk32({tag, ".waddr"}, {27'd0, ms_rf_waddr}, {27'd0, wa});
    chk1({tag, ".we"}, ms_rf_we, we);
  endtask

  task automatic chk_fwd(input string tag, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic rdy);
    chk1({tag, ".fwd_we"}, ms_fwd_we, FWD & we);
    chk32({tag, ".fwd_waddr"}, {27'd0, ms_fwd_waddr},
          FWD ? {27'd0, wa} : 32'd0);
    chk32({tag, ".fwd_wdata"}, ms_fwd_wdata, FWD ? wd : 32'd0);
    chk1({tag, ".fwd_ready"}, ms_fwd_ready, FWD & rdy);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] pc;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] exp_wd;
    logic [4:0]  wa;
    logic [2:0]  op;
    logic        we;
    int          kind;
    int          d;
    int          s;

    resetn            = 1'b0;
    es_to_ms_valid    = 1'b0;
    es_pc             = '0;
    es_rf_wdata       = '0;
    es_rf_waddr       = '0;
    es_rf_we          = 1'b0;
    es_mem_req        = 1'b0;
    es_is_load        = 1'b0;
    es_ld_op          = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allowin        = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk_wb("rst", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    chk1("rst.allowin", ms_allowin, 1'b1);
    chk_fwd("rst", 1'b0, 5'd0, 32'h0, 1'b0);
    cyc();
    resetn = 1'b1;

    // Back-to-back non-memory instructions
    cyc();
    drive_es(32'h1c00_0000, 32'h1111_0000, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    chk1("b2b.allowin0", ms_allowin, 1'b1);
    chk1("b2b.valid0", ms_to_ws_valid, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k < 3)
        drive_es(32'h1c00_0000 + 32'(k) * 4, 32'h1111_0000 + 32'(k),
                 5'(k + 1), 1'b1, 1'b0, 1'b0, 3'd0);
      else
        es_to_ms_valid = 1'b0;
      @(negedge clk);
      chk_wb("b2b", 1'b1, 32'h1c00_0000 + 32'(k - 1) * 4,
             32'h1111_0000 + 32'(k - 1), 5'(k), 1'b1);
      chk1("b2b.allowin", ms_allowin, 1'b1);
      chk_fwd("b2b", 1'b1, 5'(k), 32'h1111_0000 + 32'(k - 1), 1'b1);
    end
    cyc();
    @(negedge clk);
    chk1("b2b.drain", ms_to_ws_valid, 1'b0);

    // Load byte signed, offset 3, response 3 cycles after accept
    cyc();
    drive_es(32'h1c00_0100, 32'h1000_0003, 5'd5, 1'b1, 1'b1, 1'b1,
             3'b100);
    cyc();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1("lb.wait.valid", ms_to_ws_valid, 1'b0);
      chk1("lb.wait.allowin", ms_allowin, 1'b0);
      chk1("lb.wait.fwd_ready", ms_fwd_ready, 1'b0);
      chk1("lb.wait.fwd_we", ms_fwd_we, FWD);
      cyc();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_FF7F;
    @(negedge clk);
    chk_wb("lb", 1'b1, 32'h1c00_0100, 32'hFFFF_FF80, 5'd5, 1'b1);
    chk_fwd("lb", 1'b1, 5'd5, 32'hFFFF_FF80, 1'b1);
    cyc();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk1("lb.drain", ms_to_ws_valid, 1'b0);

    // Load half unsigned, offset 2, WB stalled across the response
    cyc();
    drive_es(32'h1c00_0200, 32'h2000_0002, 5'd7, 1'b1, 1'b1, 1'b1,
             3'b001);
    cyc();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_1234;
    ws_allowin        = 1'b0;
    @(negedge clk);
    chk_wb("lhu.ok", 1'b1, 32'h1c00_0200, 32'h0000_BEEF, 5'd7, 1'b1);
    chk1("lhu.ok.allowin", ms_allowin, 1'b0);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1111_2222;
    @(negedge clk);
    chk_wb("lhu.buf", 1'b1, 32'h1c00_0200, 32'h0000_BEEF, 5'd7, 1'b1);
    chk1("lhu.buf.allowin", ms_allowin, 1'b0);
    cyc();
    ws_allowin = 1'b1;
    @(negedge clk);
    chk_wb("lhu.rel", 1'b1, 32'h1c00_0200, 32'h0000_BEEF, 5'd7, 1'b1);
    chk1("lhu.rel.allowin", ms_allowin, 1'b1);
    cyc();
    @(negedge clk);
    chk1("lhu.drain", ms_to_ws_valid, 1'b0);

    // Store answered in its first MEM cycle
    cyc();
    drive_es(32'h1c00_0300, 32'h3000_0008, 5'd0, 1'b0, 1'b1, 1'b0, 3'd2);
    cyc();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    chk_wb("st", 1'b1, 32'h1c00_0300, 32'h3000_0008, 5'd0, 1'b0);
    chk1("st.allowin", ms_allowin, 1'b1);
    cyc();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk1("st.drain", ms_to_ws_valid, 1'b0);

    // Reset while waiting for a load response
    cyc();
    drive_es(32'h1c00_0400, 32'h4000_0001, 5'd9, 1'b1, 1'b1, 1'b1, 3'd0);
    cyc();
    es_to_ms_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk_wb("rstw", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    chk1("rstw.allowin", ms_allowin, 1'b1);
    chk_fwd("rstw", 1'b0, 5'd0, 32'h0, 1'b0);
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    chk1("rstw.after.valid", ms_to_ws_valid, 1'b0);
    chk1("rstw.after.allowin", ms_allowin, 1'b1);

    // Randomized single transactions: 0 alu, 1 load, 2 store
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(2, 0));
      d    = int'($urandom_range(2, 0));
      s    = int'($urandom_range(2, 0));
      pc   = 32'h1c00_1000 + 32'(t) * 4;
      wd   = $urandom;
      r    = $urandom;
      wa   = r[4:0];
      op   = {r[5], 2'(r[7:6] % 2'd3)};
      rd   = $urandom;
      we   = (kind != 2);
      exp_wd = (kind == 1) ? ref_load(rd, wd[1:0], op) : wd;
      cyc();
      drive_es(pc, wd, wa, we, kind != 0, kind == 1, op);
      ws_allowin = 1'b1;
      cyc();
      es_to_ms_valid = 1'b0;
      if (kind != 0) begin
        for (int i = 0; i < d; i++) begin
          data_sram_data_ok = 1'b0;
          data_sram_rdata   = $urandom;
          @(negedge clk);
          chk1("rnd.wait.valid", ms_to_ws_valid, 1'b0);
          chk1("rnd.wait.fwd_ready", ms_fwd_ready, 1'b0);
          cyc();
        end
      end
      r = $urandom;
      data_sram_data_ok = (kind != 0) ? 1'b1 : r[0];
      data_sram_rdata   = rd;
      ws_allowin        = (s == 0);
      @(negedge clk);
      chk_wb("rnd.out", 1'b1, pc, exp_wd, wa, we);
      chk1("rnd.out.allowin", ms_allowin, s == 0);
      chk_fwd("rnd.out", we, wa, exp_wd, 1'b1);
      for (int j = 0; j < s; j++) begin
        cyc();
        r = $urandom;
        data_sram_data_ok = r[0];
        data_sram_rdata   = $urandom;
        ws_allowin        = (j == s - 1);
        @(negedge clk);
        chk_wb("rnd.stall", 1'b1, pc, exp_wd, wa, we);
        chk1("rnd.stall.allowin", ms_allowin, j == s - 1);
      end
      cyc();
      data_sram_data_ok = 1'b0;
      ws_allowin        = 1'b1;
      @(negedge clk);
      chk1("rnd.idle.valid", ms_to_ws_valid, 1'b0);
      chk1("rnd.idle.allowin", ms_allowin, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
